// File: rtl/s_array_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : s_array_reader                                                  |
// | Purpose  : Sweeps the RC4 S-array RAM from START_ADDR to END_ADDR and        |
// |            streams each byte with its index over valid/ready.               |
// | Options  : S_READER_IDENTITY_CHECK_EN adds a sticky S[i]==i checker.        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module s_array_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mismatch_addr
);

  localparam int CNT_W = 2;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(END_ADDR);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               capture;
  logic               start_accept;

  assign write_enable = 1'b0;
  // The last WAIT edge is the only point where q is trusted.
  assign capture      = (state == S_WAIT) && (wait_cnt == CNT_W'(1));
  assign start_accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      address   <= FIRST_ADDR;
      wait_cnt  <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ISSUE;
            address <= FIRST_ADDR;
            busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= CNT_W'(RD_LAT);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (capture) begin
            out_data  <= q;
            out_index <= address;
            out_valid <= 1'b1;
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (address == LAST_ADDR) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              address <= address + ADDR_W'(1);
              state   <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef S_READER_IDENTITY_CHECK_EN
  logic [DATA_W-1:0] addr_as_data;
  assign addr_as_data = DATA_W'(address);

  // Only the first failing address since the last accepted start is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch      <= 1'b0;
      mismatch_addr <= '0;
    end else if (start_accept) begin
      mismatch      <= 1'b0;
      mismatch_addr <= '0;
    end else if (capture && !mismatch && (q != addr_as_data)) begin
      mismatch      <= 1'b1;
      mismatch_addr <= address;
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign mismatch      = 1'b0;
  assign mismatch_addr = '0;
`endif

endmodule
`default_nettype wire

// File: doc/s_array_reader.md
Name: s_array_reader

Overview:
- Sequential reader for the 256-byte RC4 S-array RAM. It is the read-side counterpart of the S-array initialisation writer.
- On `start`, it sweeps addresses START_ADDR..END_ADDR and issues one synchronous RAM read per address. Each returned byte goes out on a valid/ready stream together with its index.
- Used by the decrypt/KSA path and by bring-up to dump or verify S contents. It never writes memory.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, RAM read latency in cycles from the edge that samples `address` to `q` valid; legal values 1..3.
- START_ADDR, 0, first address read.
- END_ADDR, 255, last address read (inclusive); must be >= START_ADDR.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- address  output  ADDR_W  registered RAM address.
- write_enable  output  1  RAM write enable; constant 0.
- q  input  DATA_W  RAM read data.
- out_data  output  DATA_W  registered byte read from RAM.
- out_index  output  ADDR_W  address that out_data came from.
- out_valid  output  1  out_data/out_index valid.
- out_ready  input  1  consumer accepts the current byte.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final byte is accepted.
- mismatch  output  1  sticky identity-check failure (see Optional Feature).
- mismatch_addr  output  ADDR_W  first failing address.

Behaviour:
- Clock and reset: one clock `clk`. `reset_n` is asynchronous, active-low.
- Reset values: state=IDLE; address=START_ADDR; out_data=0; out_index=0; out_valid=0; busy=0; done=0; mismatch=0; mismatch_addr=0. Counters are cleared.
- Reset asserted mid-sweep aborts immediately. No `done` pulse is produced. After release the block sits in IDLE.
- States and transitions:
  - IDLE: `start`=1 at an edge → ISSUE, with address<=START_ADDR.
  - ISSUE: lasts 1 cycle; the RAM samples `address` at the edge leaving ISSUE. Next state WAIT; wait counter loaded with RD_LAT.
  - WAIT: decrements each edge. At the edge where the counter reaches 0: out_data<=q, out_index<=address, out_valid<=1, state → PRESENT.
  - PRESENT: out_valid and out_data are held stable until an edge with out_valid&&out_ready. At that handshake edge, out_valid<=0, then:
    - if address==END_ADDR → DONE;
    - else address<=address+1 → ISSUE.
  - DONE: done=1 for exactly one cycle → IDLE. `address` is left at END_ADDR.
- Timing:
  - With RD_LAT=1 and out_ready held 1, each byte takes 3 cycles: ISSUE, WAIT, PRESENT.
  - Latency from the start edge to the first out_valid is RD_LAT+1 edges.
- Boundary conditions:
  - `start` outside IDLE is ignored, including during DONE.
  - Address increment never wraps in operation, because the sweep ends at END_ADDR. With END_ADDR=255 the ADDR_W-bit counter is never incremented past 255.
  - START_ADDR==END_ADDR produces exactly one byte, then `done`.
  - out_ready asserted while out_valid=0 has no effect.
  - `q` is sampled only on the WAIT-exit edge and ignored at all other times.

Optional Feature:
- Macro: `S_READER_IDENTITY_CHECK_EN`.
- Defined: on each WAIT-exit capture, the block compares q against address[DATA_W-1:0].
  - On the first inequality since reset or since the last `start` accepted in IDLE: mismatch<=1 and mismatch_addr<=address.
  - Later mismatches do not update mismatch_addr.
  - mismatch and mismatch_addr are cleared when `start` is accepted.
  - The check confirms the S[i]=i initialisation.
- Undefined: mismatch and mismatch_addr are tied to 0 and no compare logic is built.

Test Plan:
- Identity RAM (S[i]=i), RD_LAT=1, out_ready=1, start pulse → 256 handshakes with out_data=out_index=0..255 in order. First out_valid 2 edges after start. Consecutive handshakes 3 cycles apart. done high for 1 cycle the cycle after the index-255 handshake. busy low afterwards.
- out_ready held 0 for 5 cycles at index 7 → out_valid stays 1, out_data=7 and address=7 stay stable, no increment. Releasing out_ready gives one handshake, then index 8 follows.
- RD_LAT=3, RAM model with 3-cycle latency → every out_data equals S[out_index]. Byte period is 5 cycles.
- Reset_n pulsed low while at index 100 → all outputs return to reset values asynchronously, and no done pulse is produced. A new start reads again from 0.
- With S_READER_IDENTITY_CHECK_EN defined, RAM has S[5]=0xAA and S[9]=0x00 → mismatch=1 from the index-5 capture, mismatch_addr=5 throughout; a second start clears both. Without the macro, both stay 0.
- START_ADDR=END_ADDR=42 → exactly one byte (index 42), then done. A start issued during the sweep is ignored.
